// File: rtl/axi4_sram_slave.sv
// AXI4 burst slave memory model for the 64-bit M_AXI memory port.
// Serves FIXED/INCR/WRAP bursts with byte strobes from an internal word
// array. Read and write channels have independent FSMs, one outstanding
// transaction each. Out-of-range beats answer DECERR.
// Optional build macro AXI4_SRAM_BACKPRESSURE_EN adds LFSR-driven
// handshake throttling on awready/arready/wready/rvalid.

module axi4_sram_slave #(
  parameter logic [63:0] ADDR_BASE  = 64'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 16,
  parameter int unsigned ID_W       = 5
) (
  input  logic            clock,
  input  logic            reset,

  output logic            M_AXI_awready,
  input  logic            M_AXI_awvalid,
  input  logic [ID_W-1:0] M_AXI_awid,
  input  logic [63:0]     M_AXI_awaddr,
  input  logic [7:0]      M_AXI_awlen,
  input  logic [2:0]      M_AXI_awsize,
  input  logic [1:0]      M_AXI_awburst,
  input  logic            M_AXI_awlock,
  input  logic [3:0]      M_AXI_awcache,
  input  logic [2:0]      M_AXI_awprot,
  input  logic [3:0]      M_AXI_awqos,

  output logic            M_AXI_wready,
  input  logic            M_AXI_wvalid,
  input  logic [63:0]     M_AXI_wdata,
  input  logic [7:0]      M_AXI_wstrb,
  input  logic            M_AXI_wlast,

  input  logic            M_AXI_bready,
  output logic            M_AXI_bvalid,
  output logic [ID_W-1:0] M_AXI_bid,
  output logic [1:0]      M_AXI_bresp,

  output logic            M_AXI_arready,
  input  logic            M_AXI_arvalid,
  input  logic [ID_W-1:0] M_AXI_arid,
  input  logic [63:0]     M_AXI_araddr,
  input  logic [7:0]      M_AXI_arlen,
  input  logic [2:0]      M_AXI_arsize,
  input  logic [1:0]      M_AXI_arburst,
  input  logic            M_AXI_arlock,
  input  logic [3:0]      M_AXI_arcache,
  input  logic [2:0]      M_AXI_arprot,
  input  logic [3:0]      M_AXI_arqos,

  input  logic            M_AXI_rready,
  output logic            M_AXI_rvalid,
  output logic [ID_W-1:0] M_AXI_rid,
  output logic [63:0]     M_AXI_rdata,
  output logic [1:0]      M_AXI_rresp,
  output logic            M_AXI_rlast
);

  localparam int unsigned Words    = 2 ** DEPTH_LOG2;
  localparam logic [63:0] MemBytes = 64'd8 << DEPTH_LOG2;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespDecerr = 2'b11;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  // Address decode helpers
  function automatic logic in_range(input logic [63:0] addr);
    return (addr >= ADDR_BASE) && ((addr - ADDR_BASE) < MemBytes);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [63:0] addr);
    return DEPTH_LOG2'((addr - ADDR_BASE) >> 3);
  endfunction

  // Per-beat address advance; reserved burst type behaves as INCR
  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] step;
    logic [63:0] win_mask;
    logic [63:0] inc;
    logic [63:0] res;
    step     = 64'd1 << size;
    win_mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
    inc      = addr + step;
    case (burst)
      2'b00:   res = addr;
      2'b10:   res = (addr & ~win_mask) | (inc & win_mask);
      default: res = inc;
    endcase
    return res;
  endfunction

  // Sideband attributes carry no meaning for this model
  logic unused_ok;
  assign unused_ok = ^{M_AXI_awlock, M_AXI_awcache, M_AXI_awprot, M_AXI_awqos,
                       M_AXI_arlock, M_AXI_arcache, M_AXI_arprot, M_AXI_arqos};

  // Handshake throttles
  logic a_gate;
  logic w_gate;
  logic r_gate;

`ifdef AXI4_SRAM_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11, free-running
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign w_gate = lfsr_q[0];
  assign r_gate = lfsr_q[0];
  assign a_gate = lfsr_q[1];
`else
  assign w_gate = 1'b1;
  assign r_gate = 1'b1;
  assign a_gate = 1'b1;
`endif

  logic [63:0] mem [Words];

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  w_state_e        w_state_q, w_state_d;
  logic [ID_W-1:0] w_id_q, w_id_d;
  logic [63:0]     w_addr_q, w_addr_d;
  logic [7:0]      w_len_q, w_len_d;
  logic [2:0]      w_size_q, w_size_d;
  logic [1:0]      w_burst_q, w_burst_d;
  logic [7:0]      w_cnt_q, w_cnt_d;
  logic            w_err_q, w_err_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            mem_we;
  logic            w_in_range;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign w_in_range = in_range(w_addr_q);
  assign w_idx      = word_idx(w_addr_q);

  // Write FSM state and latched request
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RespOkay;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Write FSM next state; beat len ends the burst even without wlast
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (M_AXI_awvalid && a_gate) begin
          w_id_d    = M_AXI_awid;
          w_addr_d  = M_AXI_awaddr;
          w_len_d   = M_AXI_awlen;
          w_size_d  = M_AXI_awsize;
          w_burst_d = M_AXI_awburst;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = WData;
        end
      end
      WData: begin
        if (M_AXI_wvalid && w_gate) begin
          mem_we   = w_in_range;
          w_err_d  = w_err_q | ~w_in_range;
          w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
          w_cnt_d  = w_cnt_q + 8'd1;
          if (M_AXI_wlast || (w_cnt_q == w_len_q)) begin
            bid_d     = w_id_q;
            bresp_d   = (w_err_q | ~w_in_range) ? RespDecerr : RespOkay;
            w_state_d = WResp;
          end
        end
      end
      WResp: begin
        if (M_AXI_bready) begin
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  assign M_AXI_awready = (w_state_q == WIdle) && a_gate;
  assign M_AXI_wready  = (w_state_q == WData) && w_gate;
  assign M_AXI_bvalid  = (w_state_q == WResp);
  assign M_AXI_bid     = bid_q;
  assign M_AXI_bresp   = bresp_q;

  // Byte-lane writes; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (M_AXI_wstrb[b]) begin
          mem[w_idx][8*b +: 8] <= M_AXI_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  r_state_e        r_state_q, r_state_d;
  logic [63:0]     r_addr_q, r_addr_d;
  logic [7:0]      r_len_q, r_len_d;
  logic [2:0]      r_size_q, r_size_d;
  logic [1:0]      r_burst_q, r_burst_d;
  logic [7:0]      r_cnt_q, r_cnt_d;
  logic            rvalid_q, rvalid_d;
  logic            rlast_q, rlast_d;
  logic [63:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [63:0]     rd_addr;
  logic            rd_load;

  // Read FSM state and presented beat
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_q <= RIdle;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      rid_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
    end
  end

  // Read FSM next state; a beat is fetched from mem on the edge it is loaded,
  // so a same-cycle write to that word is not yet visible
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    rd_addr   = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
    rd_load   = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        if (M_AXI_arvalid && a_gate) begin
          rd_addr   = M_AXI_araddr;
          r_addr_d  = M_AXI_araddr;
          r_len_d   = M_AXI_arlen;
          r_size_d  = M_AXI_arsize;
          r_burst_d = M_AXI_arburst;
          r_cnt_d   = '0;
          rid_d     = M_AXI_arid;
          rlast_d   = (M_AXI_arlen == 8'd0);
          rd_load   = 1'b1;
          r_state_d = RData;
        end
      end
      RData: begin
        if (rvalid_q && M_AXI_rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = RIdle;
          end else begin
            r_addr_d = rd_addr;
            r_cnt_d  = r_cnt_q + 8'd1;
            rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
            rd_load  = 1'b1;
          end
        end else if (!rvalid_q) begin
          // Beat already loaded, waiting for the throttle to open
          rvalid_d = r_gate;
        end
      end
      default: r_state_d = RIdle;
    endcase
    if (rd_load) begin
      rvalid_d = r_gate;
      if (in_range(rd_addr)) begin
        rdata_d = mem[word_idx(rd_addr)];
        rresp_d = RespOkay;
      end else begin
        rdata_d = '0;
        rresp_d = RespDecerr;
      end
    end
  end

  assign M_AXI_arready = (r_state_q == RIdle) && a_gate;
  assign M_AXI_rvalid  = rvalid_q;
  assign M_AXI_rid     = rid_q;
  assign M_AXI_rdata   = rdata_q;
  assign M_AXI_rresp   = rresp_q;
  assign M_AXI_rlast   = rlast_q;

endmodule

// File: doc/axi4_sram_slave.md
Name: axi4_sram_slave

Overview:
- AXI4 burst slave memory model on the rocketchip wrapper's 64-bit M_AXI memory port, in the verilator bench.
- Serves cached-memory traffic from the core (FIXED/INCR/WRAP bursts, byte strobes) out of an internal word array.
- Read and write channels run independent FSMs. Each channel has one outstanding transaction.

Parameters:
- ADDR_BASE, 64'h8000_0000: byte address of word 0.
- DEPTH_LOG2, 16: log2 of the number of 64-bit words.
- ID_W, 5: AXI ID width.

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- M_AXI_awready out 1; M_AXI_awvalid in 1; M_AXI_awid in ID_W; M_AXI_awaddr in 64; M_AXI_awlen in 8; M_AXI_awsize in 3; M_AXI_awburst in 2
- M_AXI_awlock in 1; M_AXI_awcache in 4; M_AXI_awprot in 3; M_AXI_awqos in 4 (all ignored)
- M_AXI_wready out 1; M_AXI_wvalid in 1; M_AXI_wdata in 64; M_AXI_wstrb in 8; M_AXI_wlast in 1
- M_AXI_bready in 1; M_AXI_bvalid out 1; M_AXI_bid out ID_W; M_AXI_bresp out 2
- M_AXI_arready out 1; M_AXI_arvalid in 1; M_AXI_arid in ID_W; M_AXI_araddr in 64; M_AXI_arlen in 8; M_AXI_arsize in 3; M_AXI_arburst in 2
- M_AXI_arlock in 1; M_AXI_arcache in 4; M_AXI_arprot in 3; M_AXI_arqos in 4 (all ignored)
- M_AXI_rready in 1; M_AXI_rvalid out 1; M_AXI_rid out ID_W; M_AXI_rdata out 64; M_AXI_rresp out 2; M_AXI_rlast out 1

Behaviour:
- Clocking and reset: one clock, `clock`. Reset `reset` is asynchronous and active-high.
- Reset values: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0.
- Memory contents are not cleared by reset. Reset mid-burst abandons the burst immediately; no response is issued.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On AW handshake, latch id, addr, len, size and burst; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes of mem[idx] enabled by wstrb, then advances the address.
  - A handshake with wlast=1 goes to W_RESP. wlast arriving before beat len+1 still ends the burst.
  - Beats beyond len are not accepted: wready drops after beat len+1 and the FSM goes to W_RESP even if wlast=0.
  - W_RESP: bvalid=1, bid=latched id. Return to W_IDLE on bready; awready is 1 again the cycle after.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On AR handshake, latch the request.
  - Cycle after the handshake: rvalid=1 with beat 0; rdata is registered from mem.
  - R_DATA: on each rvalid&&rready, the next beat is presented the following cycle, so back-to-back beats give 1 beat/cycle.
  - rlast=1 on beat len. Handshake of the last beat returns to R_IDLE.
  - rvalid, rdata, rid, rlast and rresp stay stable while rvalid&&!rready.
- Address update per beat:
  - FIXED (00): address unchanged.
  - INCR (01): addr += 1<<size.
  - WRAP (10): increment within an aligned window of (len+1)<<size bytes; the window base is addr & ~(window-1).
  - Reserved (11): treated as INCR.
- Index and decode:
  - idx = (addr - ADDR_BASE) >> 3, truncated to DEPTH_LOG2 bits.
  - A beat is in range when ADDR_BASE <= addr < ADDR_BASE + (8<<DEPTH_LOG2).
  - Out-of-range write beat: write suppressed; bresp=DECERR (2'b11) if any beat of the burst was out of range, else OKAY.
  - Out-of-range read beat: rdata=0, rresp=DECERR on that beat only.
- Read-write collision: same word written and read in the same cycle returns the old data; the write takes effect the next cycle.
- Concurrency: a read FSM and a write FSM may be active simultaneously; neither stalls the other.

Optional Feature:
- Macro: AXI4_SRAM_BACKPRESSURE_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - LFSR bit 0 gates wready in W_DATA and rvalid assertion in R_DATA; bit 1 gates awready and arready.
  - Gated-off signals read 0. Once rvalid is 1 it stays 1 until the handshake (AXI stability rule).
- When undefined: no LFSR; timing exactly as in Behaviour.

Test Plan:
- Single write then read at 0x8000_0000: AW len=0 size=3, wdata=64'h0123_4567_89AB_CDEF, wstrb=8'hFF -> bresp=0, bid=AWID. AR len=0 -> rdata=64'h0123_4567_89AB_CDEF, rlast=1, rvalid exactly 1 cycle after AR handshake.
- INCR burst: len=7 at 0x8000_0040 writing 0..7, rready held 1 -> 8 consecutive rvalid cycles, data 0..7, rlast only on beat 7.
- WRAP burst: len=3, size=3, start 0x8000_0010 -> beats hit words 2,3,0,1 of the 32-byte window.
- Partial strobe: wstrb=8'h0F with wdata=64'hFFFF_FFFF_FFFF_FFFF over word 64'h0 -> read returns 64'h0000_0000_FFFF_FFFF.
- Decode errors:
  - Write burst at 0x7FFF_FFF8, len=1 (first beat out of range) -> bresp=2'b11; word 0 is still written by beat 1.
  - Read at ADDR_BASE+(8<<DEPTH_LOG2) -> rresp=2'b11, rdata=0.
- Reset mid-read: assert reset during beat 3 of a len=7 read -> rvalid=0 and arready=1 immediately. A new AR after reset completes normally with its own rid.
